// File: rtl/bcd_pkg.sv
// Shared constants and the BCD digit type for the scanned BCD counter.
package bcd_pkg;

  localparam int        DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef logic [DIGIT_W-1:0] bcd_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 up or down when enabled, with a combinational
// carry/borrow out that tells the next decade it must step this cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic en,
  input  logic up,
  output bcd_t q,
  output logic co
);

  bcd_t q_q;
  bcd_t q_d;

  // Carry out when about to wrap 9->0 going up, borrow out on 0->9 going down.
  assign co = up ? (q_q == BCD_MAX) : (q_q == '0);
  assign q  = q_q;

  // Next decade value for one up or down step.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (up) q_d = (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
      else    q_d = (q_q == '0) ? BCD_MAX : q_q - 1'b1;
    end
  end

  // Decade register; clear wins over any step.
  always_ff @(posedge CLK) begin
    if (RST)      q_q <= '0;
    else if (CLR) q_q <= '0;
    else          q_q <= q_d;
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed single-digit scan
// output for a 7-segment decoder. Optional leading-zero blanking is enabled
// by defining LEADING_ZERO_BLANK_EN.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic                      INC,
  input  logic                      UP,
  output logic [DIGIT_W*DIGITS-1:0] VAL,
  output logic                      CARRY,
  output logic [DIGIT_W-1:0]        BCD,
  output logic [DIGITS-1:0]         DIG
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0] en;
  logic [DIGITS-1:0] co;
  bcd_t              digit [DIGITS];

  // Decade chain: a decade steps only when INC is high and every lower decade
  // is at its wrap value, so the ripple settles within one cycle.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_lsd
      assign en[g] = INC;
    end else begin : g_upper
      assign en[g] = INC & (&co[g-1:0]);
    end

    bcd_digit u_digit (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .en  (en[g]),
      .up  (UP),
      .q   (digit[g]),
      .co  (co[g])
    );

    assign VAL[g*DIGIT_W +: DIGIT_W] = digit[g];
  end

  logic carry_q;

  // Wrap/borrow pulse: set for the cycle after the whole count rolls over.
  always_ff @(posedge CLK) begin
    if (RST)      carry_q <= 1'b0;
    else if (CLR) carry_q <= 1'b0;
    else          carry_q <= INC & (&co);
  end

  assign CARRY = carry_q;

  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick;

  // Scan prescaler and digit index; independent of CLR and INC.
  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // Scan state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  bcd_t raw;

  // Digit strobe and raw digit select, straight from the live count so the
  // strobe and code never skew.
  always_comb begin
    raw = '0;
    DIG = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        raw    = digit[i];
        DIG[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic blank;

  // Blank the scanned digit when it and all higher digits are zero; the
  // least significant digit always shows so a zero count reads "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (digit[i] == '0);
      if ((idx_q == IW'(i)) && (i != 0)) blank = upper_zero;
    end
  end

  assign BCD = blank ? BLANK_CODE : raw;
`else
  assign BCD = raw;
`endif

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Multi-digit synchronous BCD up/down counter with a time-multiplexed display scan output.
- Sits directly upstream of the 7-segment decoder: drives one 4-bit BCD digit at a time on BCD, with a one-hot digit strobe on DIG for the display common lines.
- Also exposes the full packed count and a wrap/borrow pulse for cascading.

Parameters:
- DIGITS, 4: number of BCD decades; legal range 1..8.
- SCAN_DIV, 1000: CLK cycles each digit stays selected; legal range >= 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- CLR  input  1  synchronous clear of the count only; the scan position keeps running.
- INC  input  1  count strobe; one step per cycle while high.
- UP  input  1  count direction: 1 = +1, 0 = -1; sampled with INC.
- VAL  output  4*DIGITS  packed count; digit 0 (least significant) is VAL[3:0].
- CARRY  output  1  one-cycle pulse on wrap-up or borrow-down.
- BCD  output  4  BCD code of the currently scanned digit, feeding the decoder.
- DIG  output  DIGITS  one-hot select; DIG[i] = 1 while digit i is on BCD.

Behaviour:
- Reset (RST = 1 at an edge):
  - VAL = 0, CARRY = 0.
  - Scan index = 0, prescaler = 0.
  - Hence DIG = 1 (only DIG[0] set) and BCD = 0 in the cycle after reset.
- RST has priority over everything else.
- Count priority, evaluated per edge:
  - RST first.
  - CLR next: VAL <= 0, CARRY <= 0; INC is ignored that cycle.
  - INC next.
  - Otherwise hold.
- Count latency: VAL reflects INC/UP at the first edge after they are sampled (1 cycle).
- Up count:
  - Digit 0 increments; a digit at 9 becomes 0 and carries into the next digit (ripple within one cycle).
  - All digits at 9 (e.g. 9999) -> all 0, and CARRY = 1 for exactly the cycle following that edge.
- Down count:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 -> all 9, and CARRY = 1 for one cycle.
- CARRY is registered. It is 0 in every cycle not immediately following a wrap or borrow. Back-to-back wraps (DIGITS = 1, INC held) produce CARRY pulses on consecutive qualifying cycles.
- Digit codes 10-15 never occur in VAL.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and then returns to 0.
  - On the edge where prescaler = SCAN_DIV-1, the scan index advances: i -> i+1, and DIGITS-1 -> 0.
  - SCAN_DIV = 1 advances the index every cycle.
  - DIG and BCD are combinational from the scan index and VAL, so BCD always equals the VAL digit selected by DIG with no skew, including in the cycle VAL changes.
- CLR and INC never disturb the scan position.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- When defined: while the scanned digit i > 0 and it and every digit above it are 0, BCD is driven to 4'hF. The decoder's default case then produces an all-off segment pattern. Digit 0 is never blanked, so a count of 0 shows "0". DIG still strobes normally.
- When undefined: BCD always shows the raw digit. 4'hF never appears.

Decomposition:
- Package bcd_pkg:
  - constant DIGIT_W = 4.
  - constant BCD_MAX = 4'd9.
  - constant BLANK_CODE = 4'hF.
  - typedef for a 4-bit BCD digit.
- Sub-module bcd_digit: one decade register with inputs CLK, RST, CLR, en, up; outputs q[3:0] and co (carry/borrow out, combinational from q and up).
- The top-level chains DIGITS instances (each en = previous co & INC) and contains the prescaler, scan index and output mux.

Test Plan:
- Reset: DIGITS = 4, SCAN_DIV = 4; hold RST 2 cycles -> VAL = 16'h0000, CARRY = 0, DIG = 4'b0001, BCD = 0.
- Up ripple: load 0098 via 98 INC pulses with UP = 1; 2 more pulses -> VAL = 0099, then 0100; CARRY stays 0.
- Wrap/borrow:
  - From 9999, INC with UP = 1 -> VAL = 0000 and CARRY = 1 for exactly one cycle.
  - Then INC with UP = 0 -> VAL = 9999 and CARRY = 1 for one cycle.
- CLR priority: VAL = 1234, assert CLR and INC together -> next VAL = 0000, CARRY = 0; DIG sequence continues unbroken.
- Scan: VAL = 1234, SCAN_DIV = 4 -> DIG steps 0001, 0010, 0100, 1000, 0001 every 4 cycles with BCD = 4, 3, 2, 1, 4.
- Blanking (LEADING_ZERO_BLANK_EN defined): VAL = 0007 -> BCD = 7, F, F, F across the scan. VAL = 0000 -> BCD = 0, F, F, F. Without the macro -> 7, 0, 0, 0.
